speicher_arbiter: RTL

- Parametrised N-channel memory arbiter. Merges several CPU-style request/acknowledge memory ports onto one shared memory port.
- Typical channels: instruction fetch, data load/store, later DMA or debug masters.
- Generalises the single-master, level-held request handshake (request held until a one-cycle loaded/stored acknowledge) to KANAELE masters.
- Round-robin fairness; address/data captured at grant.

---
 rtl/speicher_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/speicher_arbiter.sv
// Round-robin arbiter merging several request/acknowledge memory ports onto one shared memory port.
// Address, write data and access type are captured at grant and held until the memory completes.
module speicher_arbiter #(
   parameter int KANAELE      = 2,
   parameter int ADRESSBREITE = 32,
   parameter int DATENBREITE  = 32
) (
   input  logic                              Clock,
   input  logic                              Reset,
   input  logic [KANAELE-1:0]                Lesen,
   input  logic [KANAELE-1:0]                Schreiben,
   input  logic [KANAELE*ADRESSBREITE-1:0]   Adresse,
   input  logic [KANAELE*DATENBREITE-1:0]    DatenSchreiben,
   output logic [DATENBREITE-1:0]            DatenLesen,
   output logic [KANAELE-1:0]                Fertig,
   output logic [ADRESSBREITE-1:0]           SpeicherAdresse,
   output logic [DATENBREITE-1:0]            SpeicherDatenRaus,
   output logic                              SpeicherLesen,
   output logic                              SpeicherSchreiben,
   input  logic [DATENBREITE-1:0]            SpeicherDatenRein,
   input  logic                              SpeicherFertig
);

   localparam int IW = (KANAELE > 1) ? $clog2(KANAELE) : 1;

   typedef enum logic [1:0] {LEERLAUF, ZUGRIFF, ANTWORT} zustandT;

   zustandT                 zustand;
   logic [IW-1:0]           zeiger;
   logic [IW-1:0]           gewaehlt;
   logic [KANAELE-1:0]      maske;

   logic [KANAELE-1:0]      anfrage;
   logic                    gefunden;
   logic [IW-1:0]           naechster;
   logic                    naechsterSchreibt;
   logic [ADRESSBREITE-1:0] naechsteAdresse;
   logic [DATENBREITE-1:0]  naechsteDaten;

   // Scan from the pointer upward first, then wrap around to the channels below it.
   always_comb begin
      anfrage           = (Lesen | Schreiben) & ~maske;
      gefunden          = 1'b0;
      naechster         = '0;
      naechsterSchreibt = 1'b0;
      naechsteAdresse   = '0;
      naechsteDaten     = '0;
      for (int k = 0; k < KANAELE; k++) begin
         if (!gefunden && anfrage[k] && (k >= int'(zeiger))) begin
            gefunden  = 1'b1;
            naechster = IW'(k);
         end
      end
      for (int k = 0; k < KANAELE; k++) begin
         if (!gefunden && anfrage[k] && (k < int'(zeiger))) begin
            gefunden  = 1'b1;
            naechster = IW'(k);
         end
      end
      for (int k = 0; k < KANAELE; k++) begin
         if (IW'(k) == naechster) begin
            naechsterSchreibt = Schreiben[k];
            naechsteAdresse   = Adresse[k*ADRESSBREITE +: ADRESSBREITE];
            naechsteDaten     = DatenSchreiben[k*DATENBREITE +: DATENBREITE];
         end
      end
   end

   // Arbitration FSM; the served channel is masked for one idle cycle so it can drop its request.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         zustand           <= LEERLAUF;
         zeiger            <= '0;
         gewaehlt          <= '0;
         maske             <= '0;
         Fertig            <= '0;
         DatenLesen        <= '0;
         SpeicherAdresse   <= '0;
         SpeicherDatenRaus <= '0;
         SpeicherLesen     <= 1'b0;
         SpeicherSchreiben <= 1'b0;
      end else begin
         case (zustand)
            LEERLAUF: begin
               maske <= '0;
               if (gefunden) begin
                  gewaehlt          <= naechster;
                  SpeicherAdresse   <= naechsteAdresse;
                  SpeicherDatenRaus <= naechsteDaten;
                  SpeicherSchreiben <= naechsterSchreibt;
                  SpeicherLesen     <= !naechsterSchreibt;
                  zustand           <= ZUGRIFF;
               end
            end
            ZUGRIFF: begin
               if (SpeicherFertig) begin
                  if (SpeicherLesen) begin
                     DatenLesen <= SpeicherDatenRein;
                  end
                  SpeicherLesen      <= 1'b0;
                  SpeicherSchreiben  <= 1'b0;
                  Fertig[gewaehlt]   <= 1'b1;
                  zeiger             <= (gewaehlt == IW'(KANAELE-1)) ? '0 : gewaehlt + 1'b1;
                  zustand            <= ANTWORT;
               end
            end
            ANTWORT: begin
               Fertig          <= '0;
               maske           <= '0;
               maske[gewaehlt] <= 1'b1;
               zustand         <= LEERLAUF;
            end
            default: begin
               zustand <= LEERLAUF;
            end
         endcase
      end
   end

endmodule
